// File: rtl/waveform_meter.sv
// Receive-side waveform monitor: measures period (clk cycles) and per-period
// signed min/max of a sample stream, using peak (slope) or edge (level) events.
module waveform_meter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PER_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic                         sample_valid_i,
  input  logic                         mode_i,
  input  logic                         clear_i,
  output logic        [PER_WIDTH-1:0]  period_o,
  output logic signed [DATA_WIDTH-1:0] max_o,
  output logic signed [DATA_WIDTH-1:0] min_o,
  output logic                         meas_valid_o,
  output logic                         timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE
  } state_e;

  localparam logic [PER_WIDTH-1:0]         CNT_MAX  = '1;
  // Saturating on the edge where cnt would become all-ones keeps cnt+1 in range,
  // so an event on that same edge reports period = 2^PER_WIDTH-1 naturally.
  localparam logic [PER_WIDTH-1:0]         CNT_SAT  = CNT_MAX - PER_WIDTH'(1);
  localparam logic signed [DATA_WIDTH-1:0] ZERO     = '0;

  state_e                       state_q;
  logic        [PER_WIDTH-1:0]  cnt_q;
  logic signed [DATA_WIDTH-1:0] prev_q;
  logic signed [DATA_WIDTH-1:0] max_run_q;
  logic signed [DATA_WIDTH-1:0] min_run_q;
  logic                         dir_up_q;
  logic                         low_seen_q;
  logic                         mode_q;
  logic        [PER_WIDTH-1:0]  period_q;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic signed [DATA_WIDTH-1:0] min_q;
  logic                         meas_valid_q;
  logic                         timeout_q;

  logic rearm_c;
  logic slope_ev_c;
  logic level_ev_c;
  logic event_c;
  logic sat_c;
  logic [PER_WIDTH-1:0] cnt_d;

  // Event detection and re-arm decode
  always_comb begin
    rearm_c    = clear_i | (mode_i != mode_q);
    slope_ev_c = dir_up_q & (sample_i < prev_q);
    level_ev_c = low_seen_q & (sample_i > ZERO);
    event_c    = sample_valid_i & (state_q != ST_IDLE) & (mode_q ? level_ev_c : slope_ev_c);
    sat_c      = (cnt_q == CNT_SAT);
    cnt_d      = cnt_q + PER_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      prev_q       <= '0;
      max_run_q    <= '0;
      min_run_q    <= '0;
      dir_up_q     <= 1'b0;
      low_seen_q   <= 1'b0;
      mode_q       <= 1'b0;
      period_q     <= '0;
      max_q        <= '0;
      min_q        <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      mode_q       <= mode_i;
      if (rearm_c) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        dir_up_q   <= 1'b0;
        low_seen_q <= 1'b0;
        max_run_q  <= '0;
        min_run_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (sample_valid_i) begin
              prev_q  <= sample_i;
              state_q <= ST_ARM;
            end
          end
          ST_ARM, ST_MEASURE: begin
            if (sample_valid_i) begin
              prev_q <= sample_i;
              if (sample_i > prev_q) begin
                dir_up_q <= 1'b1;
              end else if (sample_i < prev_q) begin
                dir_up_q <= 1'b0;
              end
              if (mode_q && level_ev_c) begin
                low_seen_q <= 1'b0;
              end else if (sample_i < ZERO) begin
                low_seen_q <= 1'b1;
              end
              // The event sample opens the next period's extrema window
              if (event_c) begin
                max_run_q <= sample_i;
                min_run_q <= sample_i;
              end else begin
                if (sample_i > max_run_q) max_run_q <= sample_i;
                if (sample_i < min_run_q) min_run_q <= sample_i;
              end
            end
            if (event_c) begin
              cnt_q   <= '0;
              state_q <= ST_MEASURE;
              if (state_q == ST_MEASURE) begin
                period_q     <= cnt_d;
                max_q        <= max_run_q;
                min_q        <= min_run_q;
                meas_valid_q <= 1'b1;
              end
            end else if (sat_c) begin
              cnt_q     <= '0;
              timeout_q <= 1'b1;
              state_q   <= ST_ARM;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign period_o     = period_q;
  assign max_o        = max_q;
  assign min_o        = min_q;
  assign meas_valid_o = meas_valid_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_waveform_meter.sv
// Directed bench for waveform_meter: expected measurements and timeout cycles are
// queued as stimulus is planned and checked whenever the DUT pulses an output.
module tb_waveform_meter;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] sample_i;
  logic                 sample_valid_i;
  logic                 mode_i;
  logic                 clear_i;
  logic        [PW-1:0] period_o;
  logic signed [DW-1:0] max_o;
  logic signed [DW-1:0] min_o;
  logic                 meas_valid_o;
  logic                 timeout_o;

  always #5 clk = ~clk;

  waveform_meter #(.DATA_WIDTH(DW), .PER_WIDTH(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .mode_i        (mode_i),
    .clear_i       (clear_i),
    .period_o      (period_o),
    .max_o         (max_o),
    .min_o         (min_o),
    .meas_valid_o  (meas_valid_o),
    .timeout_o     (timeout_o)
  );

  typedef struct {
    int per;
    int mx;
    int mn;
  } meas_t;

  meas_t mq[$];
  int    tq[$];
  int    ntests = 0;
  int    nfail  = 0;
  int    cyc    = 0;

  int tri_q[$]   = '{0, 1, 2, 3, 4, 3, 2, 1};
  int tri04_q[$] = '{0, 1, 2, 3, 4};
  int tri03_q[$] = '{0, 1, 2, 3, 4, 3};
  int tri02_q[$] = '{0, 1, 2};
  int saw_q[$]   = '{0, 1, 2, 3, 4, 5, 6, 7};
  int rect_q[$]  = '{-5, -5, -5, 5, 5, 5};
  int rectz_q[$] = '{0, 0, 0, 5, 5, 5};
  int plat_q[$]  = '{0, 1, 2, 2, 2, 1, 0};

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    if (meas_valid_o) begin
      chk("meas_expected", int'(mq.size() > 0), 1);
      if (mq.size() > 0) begin
        meas_t e;
        e = mq.pop_front();
        chk("period", int'(period_o), e.per);
        chk("max", int'(max_o), e.mx);
        chk("min", int'(min_o), e.mn);
      end
    end
    if (timeout_o) begin
      chk("timeout_expected", int'(tq.size() > 0), 1);
      if (tq.size() > 0) chk("timeout_cycle", cyc, tq.pop_front());
    end
  endtask

  task automatic step(input int s, input logic v);
    sample_i       = DW'(s);
    sample_valid_i = v;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic run(input int seq[$], input int reps, input bit every_other);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < seq.size(); i++) begin
        step(seq[i], 1'b1);
        if (every_other) step(-100, 1'b0);
      end
    end
  endtask

  task automatic expect_meas(input int per, input int mx, input int mn, input int n);
    meas_t e;
    e.per = per;
    e.mx  = mx;
    e.mn  = mn;
    for (int i = 0; i < n; i++) mq.push_back(e);
  endtask

  task automatic clear_step(input int s, input logic v);
    clear_i = 1'b1;
    step(s, v);
    clear_i = 1'b0;
  endtask

  task automatic chk_hold(input string tag, input int per, input int mx, input int mn);
    chk({tag, "_period"}, int'(period_o), per);
    chk({tag, "_max"}, int'(max_o), mx);
    chk({tag, "_min"}, int'(min_o), mn);
  endtask

  initial begin
    rst            = 1'b1;
    clear_i        = 1'b0;
    mode_i         = 1'b0;
    sample_i       = '0;
    sample_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_hold("reset", 0, 0, 0);
    chk("reset_meas_valid", int'(meas_valid_o), 0);
    chk("reset_timeout", int'(timeout_o), 0);
    rst = 1'b0;

    // Triangle: first drop arms, then one measurement every 8 samples
    expect_meas(8, 4, 0, 4);
    run(tri_q, 5, 1'b0);
    run(tri04_q, 1, 1'b0);
    chk("tri_drained", mq.size(), 0);
    // Clear coincides with a would-be event sample: no pulse, outputs hold
    clear_step(3, 1'b1);
    chk_hold("tri_clear_hold", 8, 4, 0);

    // Sawtooth, every cycle then every other cycle
    expect_meas(8, 7, 0, 3);
    run(saw_q, 5, 1'b0);
    chk("saw_drained", mq.size(), 0);
    clear_step(0, 1'b0);
    expect_meas(16, 7, 0, 3);
    run(saw_q, 5, 1'b1);
    chk("saw_half_drained", mq.size(), 0);

    // Rectangular in level mode
    mode_i = 1'b1;
    step(0, 1'b0);
    expect_meas(6, 5, -5, 4);
    run(rect_q, 5, 1'b0);
    chk("rect_drained", mq.size(), 0);

    // Zero never counts as low: no events at all
    clear_step(0, 1'b0);
    run(rectz_q, 4, 1'b0);
    chk_hold("rectz_hold", 6, 5, -5);

    // Plateau in slope mode
    mode_i = 1'b0;
    step(0, 1'b0);
    expect_meas(7, 2, 0, 4);
    run(plat_q, 5, 1'b0);
    chk("plat_drained", mq.size(), 0);

    // Saturation: flat input after an event, then triangle resumes
    clear_step(0, 1'b0);
    expect_meas(8, 4, 0, 2);
    run(tri_q, 2, 1'b0);
    run(tri03_q, 1, 1'b0);
    chk("pre_timeout_drained", mq.size(), 0);
    tq.push_back(cyc + 255);
    for (int i = 0; i < 280; i++) step(3, 1'b1);
    chk("timeout_drained", tq.size(), 0);
    expect_meas(8, 4, 0, 2);
    run(tri_q, 3, 1'b0);
    chk("post_timeout_drained", mq.size(), 0);

    // Asynchronous reset mid-period
    expect_meas(8, 4, 0, 3);
    run(tri_q, 3, 1'b0);
    run(tri02_q, 1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_hold("async_reset", 0, 0, 0);
    chk("async_reset_meas_valid", int'(meas_valid_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_meas(8, 4, 0, 2);
    run(tri_q, 3, 1'b0);
    chk("post_reset_drained", mq.size(), 0);

    // Mode toggle mid-run: outputs hold, then re-arm
    run(tri02_q, 1, 1'b0);
    mode_i = 1'b1;
    step(5, 1'b1);
    mode_i = 1'b0;
    step(5, 1'b1);
    chk_hold("mode_toggle_hold", 8, 4, 0);
    expect_meas(8, 4, 0, 2);
    run(tri_q, 3, 1'b0);
    chk("post_toggle_drained", mq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
